// File: rtl/gpio_pad_cfg_shift_if.sv
// Serial configuration chain link between housekeeping and a pad stage.
// The master drives data and strobes and observes the chain output.
interface gpio_pad_cfg_shift_if;
    logic serial_data_in;
    logic serial_shift_en;
    logic serial_load;
    logic serial_data_out;

    modport master (
        output serial_data_in,
        output serial_shift_en,
        output serial_load,
        input  serial_data_out
    );

    modport slave (
        input  serial_data_in,
        input  serial_shift_en,
        input  serial_load,
        output serial_data_out
    );
endinterface

// File: rtl/gpio_pad_cfg_shift.sv
// Per-pad configuration stage: serially loaded shadow word, committed on load,
// driving the GPIO pad control pins with constant-rail tie-offs when disabled.
module gpio_pad_cfg_shift #(
    parameter int                     CFG_W     = 13,
    parameter logic [CFG_W-1:0]       RESET_CFG = 13'h000B,
    parameter int                     CNT_W     = 4
) (
    input  logic              serial_clock,
    input  logic              resetn,
    gpio_pad_cfg_shift_if.slave chain,
    input  logic              const_one,
    input  logic              const_zero,
    input  logic              mgmt_gpio_out,
    input  logic              user_gpio_out,
    input  logic              user_gpio_oeb,
    output logic              pad_gpio_out,
    output logic              pad_gpio_outenb,
    output logic              pad_gpio_inenb,
    output logic [2:0]        pad_gpio_dm,
    output logic              pad_gpio_slow_sel,
    output logic [CFG_W-1:0]  cfg_word,
    output logic              load_err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CFG_W + 1);

    logic [CFG_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            shadow   <= RESET_CFG;
            cfg_word <= RESET_CFG;
            cnt      <= '0;
            load_err <= 1'b0;
        end else if (chain.serial_load) begin
            // Only an exact-length shift may commit; anything else is rejected.
            if (cnt == CNT_FULL) begin
                cfg_word <= shadow;
                load_err <= 1'b0;
            end else begin
                load_err <= 1'b1;
            end
            cnt <= '0;
        end else if (chain.serial_shift_en) begin
            shadow <= {shadow[CFG_W-2:0], chain.serial_data_in};
            if (cnt != CNT_OVER) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign chain.serial_data_out = shadow[CFG_W-1];

    always_comb begin
        pad_gpio_out      = const_zero;
        pad_gpio_outenb   = const_one;
        pad_gpio_inenb    = const_one;
        pad_gpio_dm       = {3{const_zero}};
        pad_gpio_slow_sel = const_zero;
        if (!cfg_word[7]) begin
            pad_gpio_inenb    = cfg_word[2];
            pad_gpio_dm       = cfg_word[5:3];
            pad_gpio_slow_sel = cfg_word[6];
            if (cfg_word[0]) begin
                pad_gpio_out    = mgmt_gpio_out;
                pad_gpio_outenb = cfg_word[1];
            end else begin
                pad_gpio_out    = user_gpio_out;
                pad_gpio_outenb = user_gpio_oeb;
            end
        end
    end

endmodule

// File: doc/gpio_pad_cfg_shift.md
Name: gpio_pad_cfg_shift

Overview:
- Per-pad configuration stage that consumes the buffered 1.8V constant-high and constant-low rails (const_one, const_zero) from the constant block.
- Holds a serially loaded pad configuration word and drives the GPIO pad control pins, selecting between the management and user sources.
- Instances daisy-chain through serial_data_in/serial_data_out to form the housekeeping configuration chain.
- Uses const_one/const_zero as the tie-off drive whenever the pad is disabled.

Parameters:
- CFG_W, 13: configuration word width; minimum 8.
- RESET_CFG, 13'h000B: shadow and active configuration value after reset.
- CNT_W, 4: bit-counter width; must satisfy 2^CNT_W - 1 >= CFG_W + 1.

Ports:
- serial_clock  in  1  sole clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- serial_data_in  in  1  chain serial input, MSB first.
- serial_shift_en  in  1  shift the shadow register by one bit this cycle.
- serial_load  in  1  one-cycle strobe that commits the shadow register to the active configuration.
- serial_data_out  out  1  chain output, equal to shadow[CFG_W-1] (registered).
- const_one  in  1  buffered constant high from the constant block.
- const_zero  in  1  buffered constant low from the constant block.
- mgmt_gpio_out  in  1  management output data.
- user_gpio_out  in  1  user output data.
- user_gpio_oeb  in  1  user output enable, active low.
- pad_gpio_out  out  1  pad output data.
- pad_gpio_outenb  out  1  pad output enable, active low.
- pad_gpio_inenb  out  1  pad input enable, active low.
- pad_gpio_dm  out  3  pad drive mode.
- pad_gpio_slow_sel  out  1  slow slew select.
- cfg_word  out  CFG_W  active configuration, for readback.
- load_err  out  1  sticky flag: the last load was rejected.

Behaviour:
- Configuration bit map:
  - [0] mgmt_ena
  - [1] mgmt_oeb
  - [2] inenb
  - [5:3] dm
  - [6] slow_sel
  - [7] pad_disable
  - [CFG_W-1:8] reserved; stored and read back, no effect on the pad.
- Reset (resetn low, asynchronous):
  - shadow = RESET_CFG, cfg_word = RESET_CFG, bit counter cnt = 0, load_err = 0.
  - serial_data_out = RESET_CFG[CFG_W-1].
  - With default parameters: pad_gpio_outenb = 1, pad_gpio_inenb = 0, pad_gpio_dm = 3'b001, pad_gpio_slow_sel = 0, pad_gpio_out follows mgmt_gpio_out.
- Shift (serial_shift_en = 1, serial_load = 0):
  - shadow <= {shadow[CFG_W-2:0], serial_data_in}.
  - cnt <= cnt + 1, saturating at CFG_W + 1 (overshift marker).
  - cfg_word unchanged.
- Load (serial_load = 1; takes priority, serial_shift_en ignored that cycle, shadow unchanged):
  - If cnt == CFG_W: cfg_word <= shadow, load_err <= 0.
  - Otherwise (short or overshift): cfg_word is held, load_err <= 1.
  - In both cases cnt <= 0.
- Idle (neither shift nor load): all state holds.
- serial_data_out changes only on shift or reset. It is the shadow MSB, so downstream chain stages see a one-cycle latency per stage.
- Pad outputs are combinational from cfg_word and the data inputs; they change on the cycle after a successful load.
  - pad_disable = 1: pad_gpio_out = const_zero, pad_gpio_outenb = const_one, pad_gpio_inenb = const_one, pad_gpio_dm = {3{const_zero}}, pad_gpio_slow_sel = const_zero.
  - Else if mgmt_ena = 1: pad_gpio_out = mgmt_gpio_out, pad_gpio_outenb = cfg[1].
  - Else: pad_gpio_out = user_gpio_out, pad_gpio_outenb = user_gpio_oeb.
  - When pad_disable = 0: inenb = cfg[2], dm = cfg[5:3], slow_sel = cfg[6].
- Reset asserted mid-shift discards the partial shift. The next load after reset requires a full CFG_W-bit shift.
- A load with cnt = 0 (including immediately after reset) sets load_err.

Test Plan:
- Reset: pulse resetn low -> cfg_word = 13'h000B, load_err = 0, pad_gpio_dm = 3'b001, pad_gpio_outenb = 1, serial_data_out = 0; toggle mgmt_gpio_out -> pad_gpio_out follows it.
- Good load: shift 13'h0A5C MSB first, then load -> cfg_word = 13'h0A5C, load_err = 0. During the shift, serial_data_out emits 13'h000B MSB first. With mgmt_ena = 0, pad_gpio_out = user_gpio_out and pad_gpio_dm = 3'b011.
- Short load: shift 12 bits, then load -> cfg_word unchanged, load_err = 1. A subsequent full 13-bit shift and load of 13'h0001 -> cfg_word = 13'h0001, load_err = 0.
- Overshift: shift 15 bits, then load -> load_err = 1, cfg_word held.
- Disable: load 13'h0080 -> pad_gpio_out = 0, pad_gpio_outenb = 1, pad_gpio_inenb = 1, pad_gpio_dm = 3'b000, pad_gpio_slow_sel = 0, all traced to const_zero/const_one; forcing const_zero = 1 in the bench changes pad_gpio_out to 1.
- Collisions: assert serial_shift_en and serial_load together after 13 shifts -> load commits, shadow not shifted. Assert resetn low after 6 shifts -> all state returns to reset values asynchronously.
